// File: rtl/j1_stack.sv
// Stack unit for J1-family cores: registered TOS over an async-read array,
// signed pointer delta, saturating occupancy count and sticky ovf/unf flags.
module j1_stack #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [1:0]               delta,
    input  logic                     wen,
    input  logic [width-1:0]         tos_d,
    input  logic                     err_clr,
    output logic [width-1:0]         tos,
    output logic [width-1:0]         nos,
    output logic [$clog2(depth)-1:0] sp,
    output logic [$clog2(depth):0]   count,
    output logic                     ovf,
    output logic                     unf
);

    localparam int unsigned PW   = $clog2(depth);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = PW + 2;
    localparam logic signed [CW-1:0] DEPTH_S   = CW'(depth);
    localparam logic [CNTW-1:0]      DEPTH_CNT = CNTW'(depth);

    logic [width-1:0]         mem [depth];
    logic signed [CW-1:0]     delta_x;
    logic signed [CW-1:0]     cnt_sum;
    logic [PW-1:0]            sp_next;
    logic [CNTW-1:0]          count_next;
    logic                     over;
    logic                     under;

    // Delta widened to pw+2 bits so that -2 at count=1 still reads as negative.
    assign delta_x = {{PW{delta[1]}}, delta};
    assign sp_next = sp + delta_x[PW-1:0];
    assign cnt_sum = $signed({1'b0, count}) + delta_x;
    assign over    = cnt_sum > DEPTH_S;
    assign under   = cnt_sum[CW-1];

    always_comb begin
        count_next = cnt_sum[CNTW-1:0];
        if (over) begin
            count_next = DEPTH_CNT;
        end else if (under) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos   <= '0;
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (!hold) begin
            tos   <= tos_d;
            sp    <= sp_next;
            count <= count_next;
            // A fresh error beats a simultaneous clear.
            ovf   <= (ovf & ~err_clr) | over;
            unf   <= (unf & ~err_clr) | under;
        end
    end

    // Old TOS spills to the new pointer; a reset at the edge drops the write.
    always_ff @(posedge clk) begin
        if (!hold && wen && !reset) begin
            mem[sp_next] <= tos;
        end
    end

    assign nos = mem[sp];

endmodule
